ibnalhaytham_core: RTL and testbench
====================================

# ibnalhaytham_core

Tethered single-cycle RV32I integer core for the Caravel user area, instantiated inside the project wrapper behind its tristate buffers. There is no instruction memory: the management CPU reads the core's PC over the logic analyzer, then drives the instruction word on the logic analyzer. The core executes one instruction per enabled clock. Debug state (a selectable register, flags, retire count) is exported on the user IO pads.

## Interface
- No parameters.
- `wb_clk_i`  in  1  sole clock; all state on its rising edge.
- `io_in`  in  7  wrapper pads 14:8.
  - `io_in[0]` (pad 8) = `rst`: synchronous, active-high.
  - `io_in[1]` (pad 9) = `run`.
  - `io_in[6:2]` (pads 14:10) = `dbg_sel`, the register index shown on the debug output.
- `la1_data_in`  in  32  instruction word from the management CPU.
- `la1_data_out`  out  32  current PC.
- `la1_oenb`  in  32  LA output-enable-bar; instruction is valid only when all 32 bits are 0.
- `io_out`  out  21  wrapper pads 35:15.
  - `[15:0]` = `x[dbg_sel][15:0]`
  - `[16]` = `illegal` (sticky)
  - `[17]` = `taken` (last retired instruction redirected the PC)
  - `[20:18]` = `retired[2:0]`
- `user_clock2`  in  1  unused; no logic connects to it.

## Operation
- Fire condition: `fire = !rst && run && (la1_oenb == 32'h0)`. When `fire` is high, `la1_data_in` is executed as the instruction at PC.
- State:
  - `pc[31:0]`
  - register file `x1..x31` (32 bits each); `x0` reads 0 and writes to it are discarded
  - `illegal`, `taken`, `retired[2:0]`
- Supported instructions:
  - LUI, AUIPC, JAL, JALR
  - BEQ/BNE/BLT/BGE/BLTU/BGEU
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI
  - ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND
  - FENCE, executed as a NOP with PC+4.
- Illegal instructions: any other opcode or funct3/funct7 combination, including loads, stores and SYSTEM.
  - Sets `illegal`, no register write, PC+4.
  - Still counts as retired; `taken` is cleared.
- Arithmetic rules:
  - All arithmetic is 32-bit, wrapping; no overflow detection.
  - Shift amount is `rs2[4:0]` or `shamt[4:0]`.
  - SRA/SRAI shift arithmetically.
  - SLT/BLT/BGE compare signed; the U forms compare unsigned.
- Immediates are sign-extended per the RV32I I/S/B/U/J formats.
- Next PC:
  - Default is PC+4.
  - Taken branch: PC+immB.
  - JAL: PC+immJ.
  - JALR: `(rs1+immI) & ~1`.
  - JAL/JALR write PC+4 to rd.
  - Misaligned targets (bit 1 set) are accepted without exception.
- `taken` is 1 after a taken branch, JAL or JALR; it is 0 after any other retired instruction.
- `retired` increments by 1 per fired instruction, wrapping 7→0.
- Register reads are combinational from the pre-edge state.
  - When rd equals rs1/rs2, the instruction uses the old value.

## Timing
- Reset (`rst`=1 at an edge):
  - `pc`=0, all `x1..x31`=0, `illegal`=0, `taken`=0, `retired`=0.
  - Outputs after reset: `la1_data_out`=0, `io_out`=0 (for any `dbg_sel`).
  - Reset overrides `fire` in the same cycle.
  - Reset is effective mid-program; nothing is retained.
- Latency: one cycle per instruction. On the edge where `fire`=1, PC, rd, `taken` and `retired` update together. `la1_data_out` shows the new PC immediately after that edge.
- Outputs are combinational from state: `la1_data_out` = `pc`, and `io_out` reads register `dbg_sel`. A change of `dbg_sel` is visible the same cycle.
- Stalls: when `run`=0 or any `la1_oenb` bit is 1, all state holds indefinitely. There is no partial execution.
- The management CPU must present the instruction for the PC it last read. The core performs no address check.

## Test plan
- Reset: hold `rst` for 2 cycles with random LA inputs -> `la1_data_out`=0 and `io_out`=0 for every `dbg_sel`. Asserting `rst` together with `fire` -> reset wins.
- ALU: fire `0x00500093` (ADDI x1,x0,5), `0xFFD00113` (ADDI x2,x0,-3), `0x002081B3` (ADD x3,x1,x2), `0x40208233` (SUB x4,x1,x2).
  - Expect x1=5, x2 low half=0xFFFD, x3=2, x4=8.
  - Expect PC=16 and `retired`=4.
- Control flow:
  - At PC=16, BEQ x0,x0,+8 (`0x00000463`) -> PC=24, `taken`=1.
  - Then JAL x5,+16 (`0x010002EF`) -> x5=28, PC=40.
  - Then ADDI -> `taken`=0.
- Illegal and x0:
  - LW x1,0(x0) (`0x00002083`) -> `illegal`=1 (sticky), x1 unchanged, PC+4.
  - ADDI x0,x0,1 (`0x00100013`) -> x0 reads 0.
- Stall: with `la1_oenb`=`0x00000001`, or `run`=0, apply valid instructions for 5 cycles -> PC, registers and `retired` unchanged. Releasing the stall executes on the next edge.
- Shifts/compares: x1=-8 via ADDI.
  - SRAI x6,x1,1 -> 0xFFFC.
  - SRLI x7,x1,28 -> 0x000F.
  - SLTU x8,x0,x1 -> 1.
  - SLT x9,x0,x1 -> 0.

Source files
------------

// File: rtl/ibnalhaytham_core.sv
// Tethered single-cycle RV32I core: the instruction arrives on the logic analyzer
// for the PC it exports, and retires on the next edge where fire is high.
module ibnalhaytham_core (
  input  logic        wb_clk_i,
  input  logic [6:0]  io_in,
  input  logic [31:0] la1_data_in,
  output logic [31:0] la1_data_out,
  input  logic [31:0] la1_oenb,
  output logic [20:0] io_out,
  input  logic        user_clock2
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111
  } opcode_e;

  logic        rst, run;
  logic [4:0]  dbg_sel;
  logic        fire;
  logic [31:0] pc;
  logic [31:0] regs [32];
  logic        illegal, taken;
  logic [2:0]  retired;

  // user_clock2 is deliberately left unconnected inside the core.
  logic unused_clock2;
  assign unused_clock2 = user_clock2;

  assign rst     = io_in[0];
  assign run     = io_in[1];
  assign dbg_sel = io_in[6:2];
  assign fire    = !rst && run && (la1_oenb == 32'h0);

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  assign instr  = la1_data_in;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  assign rs1_val  = regs[rs1];
  assign rs2_val  = regs[rs2];
  assign pc_plus4 = pc + 32'd4;

  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  logic        alt, alu_ok;

  // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
  always_comb begin
    alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
    shamt   = alu_b[4:0];
    alt     = (funct7 == 7'b0100000);
    alu_res = '0;
    alu_ok  = 1'b1;
    if (opcode == OP_REG)
      alu_ok = (funct7 == 7'b0) || (alt && (funct3 == 3'd0 || funct3 == 3'd5));
    else if (funct3 == 3'd1)
      alu_ok = (funct7 == 7'b0);
    else if (funct3 == 3'd5)
      alu_ok = (funct7 == 7'b0) || alt;
    case (funct3)
      3'd0: alu_res = (opcode == OP_REG && alt) ? rs1_val - alu_b : rs1_val + alu_b;
      3'd1: alu_res = rs1_val << shamt;
      3'd2: alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'd3: alu_res = {31'b0, rs1_val < alu_b};
      3'd4: alu_res = rs1_val ^ alu_b;
      3'd5: alu_res = alt ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'd6: alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  logic        br_valid, br_cond;
  logic [31:0] next_pc, wr_data;
  logic        wr_en, legal, redirect;

  always_comb begin
    br_valid = 1'b1;
    br_cond  = 1'b0;
    case (funct3)
      3'd0: br_cond = (rs1_val == rs2_val);
      3'd1: br_cond = (rs1_val != rs2_val);
      3'd4: br_cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'd5: br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6: br_cond = (rs1_val <  rs2_val);
      3'd7: br_cond = (rs1_val >= rs2_val);
      default: br_valid = 1'b0;
    endcase
  end

  always_comb begin
    next_pc  = pc_plus4;
    wr_en    = 1'b0;
    wr_data  = alu_res;
    legal    = 1'b1;
    redirect = 1'b0;
    case (opcode)
      OP_LUI: begin
        wr_en   = 1'b1;
        wr_data = imm_u;
      end
      OP_AUIPC: begin
        wr_en   = 1'b1;
        wr_data = pc + imm_u;
      end
      OP_JAL: begin
        wr_en    = 1'b1;
        wr_data  = pc_plus4;
        next_pc  = pc + imm_j;
        redirect = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'd0) begin
          wr_en    = 1'b1;
          wr_data  = pc_plus4;
          next_pc  = (rs1_val + imm_i) & ~32'd1;
          redirect = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (!br_valid) legal = 1'b0;
        else if (br_cond) begin
          next_pc  = pc + imm_b;
          redirect = 1'b1;
        end
      end
      OP_IMM, OP_REG: begin
        wr_en = alu_ok;
        legal = alu_ok;
      end
      OP_FENCE: legal = (funct3 == 3'd0);
      default:  legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      pc      <= '0;
      illegal <= 1'b0;
      taken   <= 1'b0;
      retired <= '0;
      // NOTE: the register file is explicitly cleared; reset must leave no stale architectural state.
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (fire) begin
      pc      <= next_pc;
      illegal <= illegal | !legal;
      taken   <= redirect;
      retired <= retired + 3'd1;
      if (wr_en && rd != 5'd0) regs[rd] <= wr_data;
    end
  end

  assign la1_data_out = pc;
  assign io_out       = {retired, taken, illegal, regs[dbg_sel][15:0]};

endmodule

// File: tb/tb_ibnalhaytham_core.sv
// Self-checking bench: directed program plus random instruction stream, compared
// every cycle against an instruction-level architectural model.
module tb_ibnalhaytham_core;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1, run_in = 1'b0;
  logic [4:0]  dbg_in = '0;
  logic [6:0]  io_in;
  logic [31:0] instr = '0, oenb = '1;
  logic [31:0] la1_data_out;
  logic [20:0] io_out;

  always #5 clk = ~clk;
  assign io_in = {dbg_in, run_in, rst_in};

  ibnalhaytham_core dut (
    .wb_clk_i     (clk),
    .io_in        (io_in),
    .la1_data_in  (instr),
    .la1_data_out (la1_data_out),
    .la1_oenb     (oenb),
    .io_out       (io_out),
    .user_clock2  (1'b0)
  );

  int checks = 0, failures = 0;
  bit cmp_en = 0;

  logic [31:0] m_pc;
  logic [31:0] m_x [32];
  logic        m_ill, m_tk;
  int          m_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ill = 0; m_tk = 0; m_ret = 0;
    for (int i = 0; i < 32; i++) m_x[i] = 0;
  endtask

  // Architectural effect of one retired instruction.
  task automatic model_exec(input logic [31:0] ins);
    int unsigned op, rd, f3, rs1, rs2, f7, sh;
    logic [31:0] a, b, b2, imm_i, imm_b, imm_j, res, npc;
    logic ok, wr, tk, reg_op;
    op = ins & 32'h7f; rd = (ins >> 7) & 31; f3 = (ins >> 12) & 7;
    rs1 = (ins >> 15) & 31; rs2 = (ins >> 20) & 31; f7 = ins >> 25;
    a = m_x[rs1]; b = m_x[rs2];
    imm_i = $signed(ins) >>> 20;
    imm_b = (ins[31] ? 32'hFFFFF000 : 0) | (((ins >> 7) & 1) << 11)
          | (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1);
    imm_j = (ins[31] ? 32'hFFF00000 : 0) | (((ins >> 12) & 255) << 12)
          | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1);
    ok = 1; wr = 0; tk = 0; res = 0; npc = m_pc + 4;
    case (op)
      'h37: begin res = ins & 32'hFFFFF000; wr = 1; end
      'h17: begin res = m_pc + (ins & 32'hFFFFF000); wr = 1; end
      'h6F: begin res = m_pc + 4; wr = 1; npc = m_pc + imm_j; tk = 1; end
      'h67: if (f3 == 0) begin
              res = m_pc + 4; wr = 1; npc = (a + imm_i) & ~32'd1; tk = 1;
            end else ok = 0;
      'h63: begin
        case (f3)
          0: tk = (a == b);
          1: tk = (a != b);
          4: tk = ($signed(a) < $signed(b));
          5: tk = ($signed(a) >= $signed(b));
          6: tk = (a < b);
          7: tk = (a >= b);
          default: ok = 0;
        endcase
        if (tk) npc = m_pc + imm_b;
      end
      'h13, 'h33: begin
        reg_op = (op == 'h33);
        b2 = reg_op ? b : imm_i;
        sh = b2 & 31;
        case (f3)
          0: if (reg_op && f7 == 32) res = a - b2;
             else if (reg_op && f7 != 0) ok = 0;
             else res = a + b2;
          1: if (f7 != 0) ok = 0; else res = a << sh;
          5: if (f7 == 0) res = a >> sh;
             else if (f7 == 32) res = $signed(a) >>> sh;
             else ok = 0;
          default: begin
            if (reg_op && f7 != 0) ok = 0;
            case (f3)
              2: res = ($signed(a) < $signed(b2)) ? 1 : 0;
              3: res = (a < b2) ? 1 : 0;
              4: res = a ^ b2;
              6: res = a | b2;
              default: res = a & b2;
            endcase
          end
        endcase
        wr = ok;
      end
      'h0F: ok = (f3 == 0);
      default: ok = 0;
    endcase
    if (!ok) begin wr = 0; tk = 0; npc = m_pc + 4; end
    if (wr && rd != 0) m_x[rd] = res;
    m_pc = npc; m_tk = tk; m_ill = m_ill | !ok; m_ret++;
  endtask

  task automatic step(input logic r, input logic rn, input logic [31:0] oe, input logic [31:0] ins);
    rst_in = r; run_in = rn; oenb = oe; instr = ins;
    @(posedge clk);
    if (r) model_reset();
    else if (rn && oe == 0) model_exec(ins);
    #1;
  endtask

  // Stalls the core, selects a register and checks its low half against a literal.
  task automatic peek_reg(input string name, input logic [4:0] sel, input logic [15:0] exp);
    rst_in = 0; run_in = 0; dbg_in = sel;
    @(negedge clk); #1;
    check(name, {16'b0, io_out[15:0]}, {16'b0, exp});
    check({name, "_model"}, {16'b0, m_x[sel][15:0]}, {16'b0, exp});
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc", la1_data_out, m_pc);
      check("io_out", {11'b0, io_out},
            {11'b0, 3'(m_ret % 8), m_tk, m_ill, m_x[dbg_in][15:0]});
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h13, 7'h33, 7'h0F, 7'h03};
    logic [6:0] f7;
    if ($urandom_range(0, 7) == 0) return $urandom;
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
            5'($urandom_range(0, 7)), ops[$urandom_range(0, 8)]};
  endfunction

  initial begin
    model_reset();
    step(1, 1'($urandom), $urandom, $urandom);
    step(1, 1'($urandom), $urandom, $urandom);
    cmp_en = 1;
    for (int i = 0; i < 32; i++) begin
      dbg_in = 5'(i);
      @(negedge clk); #1;
      check("reset_io", {11'b0, io_out}, 32'h0);
      check("reset_pc", la1_data_out, 32'h0);
    end

    // ALU group
    step(0, 1, 0, 32'h00500093);
    step(0, 1, 0, 32'hFFD00113);
    step(0, 1, 0, 32'h002081B3);
    step(0, 1, 0, 32'h40208233);
    peek_reg("x1", 1, 16'h0005);
    peek_reg("x2", 2, 16'hFFFD);
    peek_reg("x3", 3, 16'h0002);
    peek_reg("x4", 4, 16'h0008);
    check("alu_pc", la1_data_out, 32'd16);
    check("alu_retired", {29'b0, io_out[20:18]}, 32'd4);

    // Control flow
    step(0, 1, 0, 32'h00000463);
    check("beq_pc", la1_data_out, 32'd24);
    check("beq_taken", {31'b0, io_out[17]}, 32'd1);
    step(0, 1, 0, 32'h010002EF);
    check("jal_pc", la1_data_out, 32'd40);
    peek_reg("x5", 5, 16'd28);
    step(0, 1, 0, 32'h00100013);
    check("addi_taken", {31'b0, io_out[17]}, 32'd0);
    peek_reg("x0", 0, 16'h0000);

    // Illegal load
    step(0, 1, 0, 32'h00002083);
    check("lw_illegal", {31'b0, io_out[16]}, 32'd1);
    check("lw_pc", la1_data_out, 32'd48);
    check("wrap_retired", {29'b0, io_out[20:18]}, 32'd0);
    peek_reg("x1_kept", 1, 16'h0005);

    // Stalls
    for (int i = 0; i < 5; i++) step(0, 1, 32'h1, 32'hFF800093);
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 32'hFF800093);
    check("stall_pc", la1_data_out, 32'd48);
    peek_reg("stall_x1", 1, 16'h0005);
    step(0, 1, 0, 32'hFF800093);
    check("release_pc", la1_data_out, 32'd52);
    check("sticky_illegal", {31'b0, io_out[16]}, 32'd1);

    // Shifts and compares with x1 = -8
    step(0, 1, 0, 32'h4010D313);
    step(0, 1, 0, 32'h01C0D393);
    step(0, 1, 0, 32'h00103433);
    step(0, 1, 0, 32'h001024B3);
    peek_reg("srai", 6, 16'hFFFC);
    peek_reg("srli", 7, 16'h000F);
    peek_reg("sltu", 8, 16'h0001);
    peek_reg("slt", 9, 16'h0000);

    // Reset wins over a firing instruction
    step(1, 1, 0, 32'h00500093);
    check("rst_fire_pc", la1_data_out, 32'h0);
    peek_reg("rst_fire_x1", 1, 16'h0000);

    // Random stream
    for (int n = 0; n < 3000; n++) begin
      dbg_in = 5'($urandom_range(0, 9));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) != 0,
           ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0,
           rand_instr());
    end
    step(0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
